// File: rtl/lii_wh_alloc.sv
// Wormhole output-port allocator: round-robin pick at packet boundaries, grant held until tail.
// Optional watchdog force-release is enabled by defining LII_WH_ALLOC_WDOG_EN.
module lii_wh_alloc #(
  parameter int N   = 4,
  parameter int DW  = 32,
  parameter int TMO = 256
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic [N-1:0]    owner,
  output logic            busy,
  output logic            err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] oidx_q, oidx_d;
  logic [N-1:0]  owner_q, owner_d;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [PW-1:0]  win_off;
  logic [PW:0]    win_sum;
  logic [PW-1:0]  win_idx;
  logic           win_any;
  logic [PW-1:0]  ptr_inc;
  logic           xfer;
  logic           tail_xfer;
  logic           tmo;

  if (N < 1 || TMO < 2) begin : g_param_chk
    $error("lii_wh_alloc: N must be >= 1 and TMO >= 2");
  end

  // Rotate requests so bit 0 is the input at ptr; lowest set bit wins.
  assign req_dbl = {in_valid, in_valid} >> ptr_q;
  assign req_rot = req_dbl[N-1:0];

  always_comb begin
    win_off = '0;
    win_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_off = PW'(k);
        win_any = 1'b1;
      end
    end
  end

  always_comb begin
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= (PW + 1)'(N)) begin
      win_idx = PW'(win_sum - (PW + 1)'(N));
    end else begin
      win_idx = win_sum[PW-1:0];
    end
  end

  assign ptr_inc = (oidx_q == PW'(N - 1)) ? '0 : oidx_q + 1'b1;

  // owner_q is all-zero in IDLE, so the AND-OR mux quiets every output there.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (owner_q[i]) begin
        out_data = out_data | in_data[i*DW +: DW];
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = owner_q[gi] & out_ready;
  end

  assign out_valid = |(owner_q & in_valid);
  assign out_last  = |(owner_q & in_last);
  assign owner     = owner_q;
  assign busy      = (state_q == S_LOCK);
  assign xfer      = out_valid & out_ready;
  assign tail_xfer = xfer & out_last;

`ifdef LII_WH_ALLOC_WDOG_EN
  localparam int CW = $clog2(TMO);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // A transfer on the timeout cycle wins over the force-release.
  assign tmo = busy & ~xfer & (cnt_q == CW'(TMO - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!busy || xfer || tmo) begin
      cnt_d = '0;
    end
    err_d = err_q | tmo;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    oidx_d  = oidx_q;
    owner_d = owner_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_any) begin
          state_d = S_LOCK;
          oidx_d  = win_idx;
          owner_d = N'(1) << win_idx;
        end
      end
      S_LOCK: begin
        if (tail_xfer || tmo) begin
          state_d = S_IDLE;
          owner_d = '0;
          ptr_d   = ptr_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      oidx_q  <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      oidx_q  <= oidx_d;
      owner_q <= owner_d;
    end
  end

endmodule
